perf_counter_controller: RTL
============================

PERF_COUNTER_CONTROLLER -- requirements
Module: perf_counter_controller

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 7, number of counters; index order matches PerfCounterPath (0 = numIC_Miss … 6 = numMemDepPredMiss).
REQ-002 SHALL have parameter CNT_WIDTH, default 32 (DataPath width), counter width.
REQ-003 SHALL have parameter INC_WIDTH, default 2, width of per-counter increment per cycle.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port incEvent  input  NUM_COUNTERS*INC_WIDTH  per-counter increment amount this cycle; unsigned.
REQ-007 SHALL have port cmdValid  input  1  command request.
REQ-008 SHALL have port cmdCode  input  2  command: 0 CLEAR, 1 FREEZE, 2 RUN, 3 DUMP.
REQ-009 SHALL have port cmdReady  output  1  command accepted when cmdValid && cmdReady.
REQ-010 SHALL have port dumpValid  output  1  dump beat valid.
REQ-011 SHALL have port dumpReady  input  1  dump beat consumed when dumpValid && dumpReady.
REQ-012 SHALL have port dumpIndex  output  $clog2(NUM_COUNTERS)  counter index of current beat.
REQ-013 SHALL have port dumpData  output  CNT_WIDTH  snapshot value of counter dumpIndex.
REQ-014 SHALL have port counterOut  output  NUM_COUNTERS*CNT_WIDTH  live counter values (packable into PerfCounterPath).
REQ-015 SHALL have port overflow  output  NUM_COUNTERS  sticky per-counter overflow flags.
REQ-016 SHALL have port running  output  1  counting enabled.

Function
REQ-017 SHALL, when running=1, add incEvent[i] to counter i every cycle; when running=0, hold all counters.
REQ-018 SHALL set overflow[i] in the cycle after the one where counter+increment exceeds 2^CNT_WIDTH-1; flag holds until CLEAR or rst.
REQ-019 SHALL implement dump FSM states IDLE, SNAP, SEND; cmdReady=1 only in IDLE.
REQ-020 SHALL on accepted CLEAR: all counters and overflow flags = 0 next cycle; that cycle's incEvent discarded; FSM stays IDLE.
REQ-021 SHALL on accepted FREEZE set running=0 next cycle; on RUN set running=1 next cycle; the accept-cycle increment still follows the old running value.
REQ-022 SHALL on accepted DUMP go IDLE->SNAP; in SNAP copy all counters (values at end of that cycle's update, including its increments) into a shadow array, then go to SEND with dumpIndex=0.
REQ-023 SHALL in SEND hold dumpValid=1 with stable dumpIndex/dumpData until dumpReady; on handshake increment dumpIndex; on handshake at index NUM_COUNTERS-1 return to IDLE with dumpValid=0 next cycle.
REQ-024 SHALL keep counting (per running) during SNAP and SEND; dumpData always comes from the shadow, never live values.
REQ-025 SHALL make a full dump with dumpReady tied high take exactly 1 (SNAP) + NUM_COUNTERS (SEND) cycles after the accept cycle.
REQ-026 SHALL ignore cmdValid while not IDLE (no queueing); requester holds cmdValid until cmdReady.

Reset
REQ-027 SHALL on rst=1 at a clock edge: counters=0, shadow=0, overflow=0, running=1, FSM=IDLE, dumpValid=0, dumpIndex=0, cmdReady=1 from the next cycle; any in-flight dump is abandoned with no further beats.

Configuration
REQ-028 SHALL honour macro RSD_PERF_COUNTER_SATURATE_EN: if defined, a counter that would overflow sticks at 2^CNT_WIDTH-1; if undefined, it wraps modulo 2^CNT_WIDTH; overflow flag behaviour is identical in both.

Structure
REQ-029 SHALL place in DebugTypes: PerfCounterCmd enum (CLEAR/FREEZE/RUN/DUMP), PerfCounterDumpState enum (IDLE/SNAP/SEND), constant PERF_COUNTER_NUM=7.
REQ-030 SHALL use one sub-module perf_counter_cell (one counter: add, clear, hold, saturate/wrap, overflow flag), instantiated NUM_COUNTERS times.

Verification
REQ-031 SHALL cover: rst, incEvent[2]=1 for 10 cycles -> counterOut[2]=10, others 0, overflow=0.
REQ-032 SHALL cover: counter 0 preloaded to 0xFFFFFFFE by counting, then inc 3 -> macro on: 0xFFFFFFFF, overflow[0]=1; macro off: 0x00000001, overflow[0]=1.
REQ-033 SHALL cover: counters = {1..7}, DUMP, dumpReady low 3 cycles, then high -> 7 beats, indices 0..6, data 1..7, stable during stall; live increments during dump are not seen in dumpData.
REQ-034 SHALL cover: FREEZE then incEvent all 3 for 5 cycles -> counters unchanged; RUN -> counting resumes the cycle after accept.
REQ-035 SHALL cover: CLEAR with simultaneous incEvent=2 -> all counters 0 next cycle; DUMP issued during SEND -> cmdReady=0, ignored.
REQ-036 SHALL cover: rst asserted mid-SEND at index 3 -> dumpValid=0, FSM IDLE, counters 0 the next cycle.

Source files
------------

// File: rtl/perf_counter_controller_pkg.sv
// Shared debug types for the performance counter block: command and dump-state
// encodings plus default sizing.
package perf_counter_controller_pkg;

  localparam int PERF_COUNTER_NUM       = 7;
  localparam int PERF_COUNTER_CNT_WIDTH = 32;
  localparam int PERF_COUNTER_INC_WIDTH = 2;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    FREEZE = 2'd1,
    RUN    = 2'd2,
    DUMP   = 2'd3
  } PerfCounterCmd;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2
  } PerfCounterDumpState;

  // Index width that stays legal for a single-counter build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One performance counter: add, clear, hold, wrap or saturate, sticky overflow.
// Build option RSD_PERF_COUNTER_SATURATE_EN makes an overflowing counter stick at all-ones.
module perf_counter_cell #(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] count_next,
  output logic                 overflow
);

  logic [CNT_WIDTH:0]   sum;
  logic                 carry;
  logic [CNT_WIDTH-1:0] added;

  always_comb begin
    sum   = {1'b0, count} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
    carry = sum[CNT_WIDTH];
`ifdef RSD_PERF_COUNTER_SATURATE_EN
    added = carry ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
`else
    added = sum[CNT_WIDTH-1:0];
`endif
  end

  // count_next is also what the dump snapshot captures, so it must include
  // this cycle's increment and clear.
  always_comb begin
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = added;
    end else begin
      count_next = count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (clear) begin
        overflow <= 1'b0;
      end else if (enable && carry) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_controller.sv
// Performance counter bank with CLEAR/FREEZE/RUN/DUMP command port and a
// snapshot-based dump stream. Counter overflow mode set by RSD_PERF_COUNTER_SATURATE_EN.
//
// state | meaning
// IDLE  | accepting commands, cmdReady=1
// SNAP  | copy post-update counter values into the shadow array
// SEND  | stream shadow entries 0..NUM_COUNTERS-1, one per dumpReady handshake
module perf_counter_controller
  import perf_counter_controller_pkg::*;
#(
  parameter int NUM_COUNTERS = PERF_COUNTER_NUM,
  parameter int CNT_WIDTH    = PERF_COUNTER_CNT_WIDTH,
  parameter int INC_WIDTH    = PERF_COUNTER_INC_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_COUNTERS*INC_WIDTH-1:0] incEvent,
  input  logic                              cmdValid,
  input  logic [1:0]                        cmdCode,
  output logic                              cmdReady,
  output logic                              dumpValid,
  input  logic                              dumpReady,
  output logic [idx_width(NUM_COUNTERS)-1:0] dumpIndex,
  output logic [CNT_WIDTH-1:0]              dumpData,
  output logic [NUM_COUNTERS*CNT_WIDTH-1:0] counterOut,
  output logic [NUM_COUNTERS-1:0]           overflow,
  output logic                              running
);

  localparam int IDX_W = idx_width(NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);

  PerfCounterDumpState state_q, state_d;
  PerfCounterCmd       cmd;
  logic                run_q, run_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                clear_cnt;
  logic                snap_en;

  logic [CNT_WIDTH-1:0] cnt      [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_COUNTERS];

  assign cmd = PerfCounterCmd'(cmdCode);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    idx_d     = idx_q;
    cmdReady  = 1'b0;
    dumpValid = 1'b0;
    clear_cnt = 1'b0;
    snap_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          unique case (cmd)
            CLEAR:  clear_cnt = 1'b1;
            FREEZE: run_d     = 1'b0;
            RUN:    run_d     = 1'b1;
            DUMP:   state_d   = SNAP;
            default: ;
          endcase
        end
      end
      SNAP: begin
        snap_en = 1'b1;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        dumpValid = 1'b1;
        if (dumpReady) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      run_q   <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (snap_en) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        shadow_q[i] <= cnt_next[i];
      end
    end
  end

  // Counters run on the registered enable, so an accepted FREEZE/RUN only
  // changes counting from the following cycle.
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH),
      .INC_WIDTH(INC_WIDTH)
    ) u_cell (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear_cnt),
      .enable    (run_q),
      .inc       (incEvent[i*INC_WIDTH +: INC_WIDTH]),
      .count     (cnt[i]),
      .count_next(cnt_next[i]),
      .overflow  (overflow[i])
    );
    assign counterOut[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  assign dumpIndex = idx_q;
  assign dumpData  = shadow_q[idx_q];
  assign running   = run_q;

endmodule
